adder: RTL and testbench

Pipelined IEEE-754 single-precision (binary32) floating-point adder. It accepts one operand pair per clock and returns the rounded sum three clocks later with a matching valid flag. It sits in the datapath as a self-contained arithmetic unit with no backpressure.

---
 rtl/fp32_pkg.sv | 45 ++++
 rtl/fp_lzc27.sv | 22 ++
 rtl/adder.sv | 210 +++++++++++++++++++++
 tb/tb_adder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pkg
// Description : Shared binary32 widths, constants and operand unpacking.
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;
    localparam int SIG_W   = FRAC_W + 4;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF = 32'hFF80_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W:0]   sig;
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
    } fp_unpacked_t;

    // Subnormals get effective exponent 1 so alignment treats them uniformly.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        e         = x[30:23];
        f         = x[22:0];
        u.sign    = x[31];
        u.exp     = (e == '0) ? EXP_W'(1) : e;
        u.sig     = {(e != '0), f};
        u.is_nan  = (e == EXP_W'(EXP_MAX)) && (f != '0);
        u.is_inf  = (e == EXP_W'(EXP_MAX)) && (f == '0);
        u.is_zero = (e == '0) && (f == '0);
        return u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc27.sv
`default_nettype none
// ============================================================================
// Module      : fp_lzc27
// Description : 27-bit leading-zero counter; all-zero input yields 27.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_lzc27 (
    input  logic [26:0] i_data,
    output logic [4:0]  o_count
);

    always_comb begin
        o_count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (i_data[i]) begin
                o_count = 5'(26 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
// Module      : adder
// Description : 3-stage pipelined binary32 adder, round-to-nearest-even.
// Revision    : 1.0 - initial release
// ============================================================================
module adder
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] op_1,
    input  logic [31:0] op_2,
    output logic [31:0] res,
    output logic        val
);

    // ---------------- stage 1: unpack, classify, swap, align ----------------
    fp_unpacked_t w_a;
    fp_unpacked_t w_b;
    logic              w_a_ge;
    logic              w_sign_l;
    logic [EXP_W-1:0]  w_exp_l;
    logic [EXP_W-1:0]  w_diff;
    logic [FRAC_W:0]   w_sig_l;
    logic [FRAC_W:0]   w_sig_s;
    logic [4:0]        w_sh;
    logic [53:0]       w_wide;
    logic [SIG_W-1:0]  w_s_aligned;
    logic              w_spec;
    logic [31:0]       w_spec_res;
    logic              w_neg_zero;

    assign w_a      = fp_unpack(op_1);
    assign w_b      = fp_unpack(op_2);
    assign w_a_ge   = (op_1[30:0] >= op_2[30:0]);
    assign w_sign_l = w_a_ge ? w_a.sign : w_b.sign;
    assign w_exp_l  = w_a_ge ? w_a.exp  : w_b.exp;
    assign w_diff   = w_a_ge ? (w_a.exp - w_b.exp) : (w_b.exp - w_a.exp);
    assign w_sig_l  = w_a_ge ? w_a.sig : w_b.sig;
    assign w_sig_s  = w_a_ge ? w_b.sig : w_a.sig;
    assign w_sh     = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
    assign w_wide   = {w_sig_s, 3'b000, 27'b0} >> w_sh;
    // Everything shifted past the S position collapses into sticky.
    assign w_s_aligned = {w_wide[53:28], w_wide[27] | (|w_wide[26:0])};
    assign w_neg_zero  = w_a.is_zero & w_b.is_zero & w_a.sign & w_b.sign;

    always_comb begin
        w_spec     = 1'b1;
        w_spec_res = QNAN;
        if (w_a.is_nan || w_b.is_nan) begin
            w_spec_res = QNAN;
        end else if (w_a.is_inf && w_b.is_inf && (w_a.sign != w_b.sign)) begin
            w_spec_res = QNAN;
        end else if (w_a.is_inf) begin
            w_spec_res = w_a.sign ? NEG_INF : POS_INF;
        end else if (w_b.is_inf) begin
            w_spec_res = w_b.sign ? NEG_INF : POS_INF;
        end else begin
            w_spec = 1'b0;
        end
    end

    logic              r_s1_val;
    logic              r_s1_sign;
    logic              r_s1_sub;
    logic [EXP_W-1:0]  r_s1_exp;
    logic [SIG_W-1:0]  r_s1_sig_l;
    logic [SIG_W-1:0]  r_s1_sig_s;
    logic              r_s1_spec;
    logic [31:0]       r_s1_spec_res;
    logic              r_s1_neg_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_val      <= 1'b0;
            r_s1_sign     <= 1'b0;
            r_s1_sub      <= 1'b0;
            r_s1_exp      <= '0;
            r_s1_sig_l    <= '0;
            r_s1_sig_s    <= '0;
            r_s1_spec     <= 1'b0;
            r_s1_spec_res <= '0;
            r_s1_neg_zero <= 1'b0;
        end else begin
            r_s1_val      <= en;
            r_s1_sign     <= w_sign_l;
            r_s1_sub      <= w_a.sign ^ w_b.sign;
            r_s1_exp      <= w_exp_l;
            r_s1_sig_l    <= {w_sig_l, 3'b000};
            r_s1_sig_s    <= w_s_aligned;
            r_s1_spec     <= w_spec;
            r_s1_spec_res <= w_spec_res;
            r_s1_neg_zero <= w_neg_zero;
        end
    end

    // ---------------- stage 2: significand add/subtract ----------------
    // Larger magnitude is always on the left, so the difference never goes negative.
    logic [SIG_W:0] w_sum;
    assign w_sum = r_s1_sub ? ({1'b0, r_s1_sig_l} - {1'b0, r_s1_sig_s})
                            : ({1'b0, r_s1_sig_l} + {1'b0, r_s1_sig_s});

    logic              r_s2_val;
    logic              r_s2_sign;
    logic [EXP_W-1:0]  r_s2_exp;
    logic [SIG_W:0]    r_s2_sum;
    logic              r_s2_spec;
    logic [31:0]       r_s2_spec_res;
    logic              r_s2_neg_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_val      <= 1'b0;
            r_s2_sign     <= 1'b0;
            r_s2_exp      <= '0;
            r_s2_sum      <= '0;
            r_s2_spec     <= 1'b0;
            r_s2_spec_res <= '0;
            r_s2_neg_zero <= 1'b0;
        end else begin
            r_s2_val      <= r_s1_val;
            r_s2_sign     <= r_s1_sign;
            r_s2_exp      <= r_s1_exp;
            r_s2_sum      <= w_sum;
            r_s2_spec     <= r_s1_spec;
            r_s2_spec_res <= r_s1_spec_res;
            r_s2_neg_zero <= r_s1_neg_zero;
        end
    end

    // ---------------- stage 3: normalise, round, pack, select ----------------
    logic [4:0]        w_lz;
    logic [EXP_W-1:0]  w_lim;
    logic [EXP_W-1:0]  w_shl;
    logic [SIG_W-1:0]  w_m;
    logic [EXP_W:0]    w_e;
    logic [EXP_W:0]    w_e_pre;
    logic              w_rnd_up;
    logic [24:0]       w_mant_r;
    logic [EXP_W:0]    w_e_fin;
    logic [FRAC_W-1:0] w_frac;
    logic [31:0]       w_res;

    fp_lzc27 u_lzc (
        .i_data  (r_s2_sum[SIG_W-1:0]),
        .o_count (w_lz)
    );

    // Left shift stops at exponent 1 so tiny results fall out as subnormals.
    assign w_lim = r_s2_exp - 8'd1;
    assign w_shl = ({3'b000, w_lz} > w_lim) ? w_lim : {3'b000, w_lz};

    always_comb begin
        if (r_s2_sum[SIG_W]) begin
            w_m = {r_s2_sum[SIG_W:2], r_s2_sum[1] | r_s2_sum[0]};
            w_e = {1'b0, r_s2_exp} + 9'd1;
        end else begin
            w_m = r_s2_sum[SIG_W-1:0] << w_shl;
            w_e = {1'b0, r_s2_exp} - {1'b0, w_shl};
        end
    end

    assign w_e_pre  = w_m[26] ? w_e : 9'd0;
    assign w_rnd_up = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    assign w_mant_r = {1'b0, w_m[26:3]} + {24'd0, w_rnd_up};

    always_comb begin
        if (w_mant_r[24]) begin
            w_e_fin = w_e_pre + 9'd1;
            w_frac  = w_mant_r[23:1];
        end else if ((w_e_pre == 9'd0) && w_mant_r[23]) begin
            w_e_fin = 9'd1;
            w_frac  = w_mant_r[22:0];
        end else begin
            w_e_fin = w_e_pre;
            w_frac  = w_mant_r[22:0];
        end
    end

    always_comb begin
        w_res = {r_s2_sign, w_e_fin[7:0], w_frac};
        if (r_s2_spec) begin
            w_res = r_s2_spec_res;
        end else if (r_s2_sum == '0) begin
            w_res = {r_s2_neg_zero, 31'd0};
        end else if (w_e_fin >= 9'(EXP_MAX)) begin
            w_res = r_s2_sign ? NEG_INF : POS_INF;
        end
    end

    logic [31:0] r_s3_res;
    logic        r_s3_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s3_res <= '0;
            r_s3_val <= 1'b0;
        end else begin
            r_s3_res <= w_res;
            r_s3_val <= r_s2_val;
        end
    end

    assign res = r_s3_res;
    assign val = r_s3_val;

endmodule
`default_nettype wire

// File: tb/tb_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder
// Description : Scoreboard bench for the pipelined binary32 adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] op_1;
    logic [31:0] op_2;
    logic [31:0] res;
    logic        val;

    int n_total;
    int n_bad;

    logic [32:0] q_exp[$];
    string       q_tag[$];

    adder dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .op_1  (op_1),
        .op_2  (op_2),
        .res   (res),
        .val   (val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input string tag, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        en   = v;
        op_1 = a;
        op_2 = b;
        q_exp.push_back({v, exp});
        q_tag.push_back(tag);
    endtask

    task automatic idle();
        drive("idle", 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    // An entry pushed before edge N is visible just after edge N+2.
    always @(posedge clk) begin
        logic [32:0] e;
        string       t;
        #1;
        if (reset && q_exp.size() >= 3) begin
            e = q_exp.pop_front();
            t = q_tag.pop_front();
            check_eq({t, "_val"}, {31'd0, val}, {31'd0, e[32]});
            if (e[32]) begin
                check_eq(t, res, e[31:0]);
            end
        end
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b0;
        en      = 1'b0;
        op_1    = '0;
        op_2    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_res", res, 32'h0);
        check_eq("rst_val", {31'd0, val}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        q_exp.push_back({1'b0, 32'h0});
        q_tag.push_back("idle");

        // 13.120413 + 12.234514 as binary32 -> 25.354927
        drive("sum13_12", 1'b1, 32'h4151ED36, 32'h4143C092, 32'h41CAD6E4);
        drive("inf_minf", 1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
        drive("nan",      1'b1, 32'h7F800001, 32'h00000001, 32'h7FC00000);
        drive("inf_fin",  1'b1, 32'h7F800000, 32'h00000001, 32'h7F800000);
        drive("one_two",  1'b1, 32'h3F800000, 32'h40000000, 32'h40400000);
        drive("tie_even", 1'b1, 32'h3F800000, 32'h33800000, 32'h3F800000);
        drive("tie_odd",  1'b1, 32'h3F800001, 32'h33800000, 32'h3F800002);
        drive("cancel",   1'b1, 32'h3F800000, 32'hBF800000, 32'h00000000);
        drive("sub_neg",  1'b1, 32'h40400000, 32'hBF800000, 32'h40000000);
        drive("sub_min",  1'b1, 32'h00000001, 32'h00000001, 32'h00000002);
        drive("sub_norm", 1'b1, 32'h00400000, 32'h00400000, 32'h00800000);
        drive("ovf",      1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        drive("neg_ovf",  1'b1, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000);
        drive("negzero",  1'b1, 32'h80000000, 32'h80000000, 32'h80000000);
        drive("mixzero",  1'b1, 32'h80000000, 32'h00000000, 32'h00000000);

        drive("tog1",     1'b1, 32'h3F800000, 32'h40000000, 32'h40400000);
        drive("tog2",     1'b0, 32'h3F800000, 32'h3F800000, 32'h0);
        drive("tog3",     1'b1, 32'h40000000, 32'h40000000, 32'h40800000);

        for (int i = 0; i < 5; i++) begin
            drive("pre_rst", 1'b1, 32'h3F800000, 32'h3F800000, 32'h40000000);
        end

        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        q_exp.delete();
        q_tag.delete();
        #1;
        check_eq("mid_rst_res", res, 32'h0);
        check_eq("mid_rst_val", {31'd0, val}, 32'd0);
        repeat (2) @(negedge clk);
        check_eq("hold_rst_val", {31'd0, val}, 32'd0);

        reset = 1'b1;
        q_exp.push_back({1'b0, 32'h0});
        q_tag.push_back("idle");
        idle();
        idle();
        drive("post_rst", 1'b1, 32'h40000000, 32'h40000000, 32'h40800000);
        for (int i = 0; i < 4; i++) begin
            idle();
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
